pet_needs_engine: RTL
=====================

Name: pet_needs_engine

Overview:
Parametrised successor to the fixed three-need pet controller. Tracks N_CH need meters (hunger, energy, fun, ...) of LVL_W bits each. Meters decay on a scalable game clock and refill on debounced button pulses. The block adds a selectable 2^k time-acceleration mode, a grace timer that ends in a sticky DEAD state, and a prioritised pet state. It sits between the debounce stage and the display/image controller.

Parameters:
N_CH, 3, number of need channels (1..8)
LVL_W, 3, bits per meter; MAX_LVL = 2^LVL_W-1
TICK_DIV, 50_000_000, clk cycles per game second at 1x; must be >= 2^MAX_ACCEL_LOG
MAX_ACCEL_LOG, 3, highest acceleration exponent (speeds 1x..2^MAX_ACCEL_LOG x)
DECAY_SEC, 5, game seconds per one-step decay of all meters
FILL_STEP, 2, increment applied per fill pulse
LOW_THR, 2, a meter at or below this value sets NEED
GRACE_SEC, 10, game seconds any meter may sit at 0 before DEAD

Ports:
clk  in  1  system clock, 50 MHz
rst_neg  in  1  synchronous active-low reset, sampled on rising clk
fill_pulse  in  N_CH  one-cycle debounced pulses; bit i refills channel i
speed_pulse  in  1  one-cycle pulse; cycles the acceleration exponent
sick_in  in  1  level signal from the temperature sensor path; 1 = sick
level_o  out  N_CH*LVL_W  packed meters; channel i occupies [i*LVL_W +: LVL_W]
zero_o  out  N_CH  bit i = (level i == 0)
accel_o  out  clog2(MAX_ACCEL_LOG+1)  current exponent k
sec_tick_o  out  1  one-cycle pulse per game second
state_o  out  3  0 OK, 1 NEED, 2 CRITICAL, 3 SICK, 4 DEAD

Behaviour:
- Reset (rst_neg=0 at clk edge): all meters = MAX_LVL; accel = 0; prescaler, decay counter and grace counter = 0; sec_tick_o = 0; dead = 0; state_o = OK. Reset mid-operation restores all of these on the next edge, with no partial state kept.
- Prescaler: counts 0..(TICK_DIV>>k)-1. sec_tick_o pulses high for exactly one cycle on the cycle the count wraps; the pulse is registered.
- speed_pulse: k <= (k==MAX_ACCEL_LOG) ? 0 : k+1. The prescaler clears in the same cycle, so the first tick at the new speed comes a full new period later. If speed_pulse and a wrap coincide, the tick is still emitted and the prescaler restarts at 0.
- Decay counter: advances on sec_tick and counts 0..DECAY_SEC-1. On the wrap, every meter with value > 0 decrements by 1; 0 stays 0.
- Fill: on fill_pulse[i], meter i <= min(v + FILL_STEP, MAX_LVL). Width-safe: compute in LVL_W+1 bits.
- Simultaneous decay and fill on the same channel in the same cycle: apply the saturating decay first, then the saturating fill, both in one cycle. For example, 0 -> 0 -> FILL_STEP.
- Multiple fill bits may be set at once, and each channel is handled independently.
- Grace counter: increments on sec_tick while any zero_o bit is set. It clears immediately, with no wait for a tick, once no meter is 0. When it reaches GRACE_SEC, dead <= 1.
- dead is sticky until reset. While dead: meters freeze, decay stops, fills and speed_pulse are ignored. sec_tick_o keeps pulsing.
- state_o is registered from the post-update meters, so it lags level_o by one cycle. Priority order: DEAD > SICK (sick_in) > CRITICAL (any meter 0) > NEED (any meter <= LOW_THR) > OK.
- zero_o and level_o are direct register outputs with no added latency.
- No handshake is used: inputs are single-cycle pulses and every accepted pulse is acted on in its own cycle. A pulse held high for multiple cycles counts once per cycle, and this is legal.

Decomposition:
- Shared package pet_pkg holds:
  - the state encoding constants (ST_OK..ST_DEAD) and the 3-bit state width;
  - helper function sat_add(v, step, max).
- One sub-module, game_tick_gen, covers the prescaler, acceleration exponent and sec_tick_o generation. It has parameters TICK_DIV and MAX_ACCEL_LOG, and ports clk, rst_neg, speed_pulse, freeze, accel_o and sec_tick_o.
- Meters, grace timer and state logic stay in the top.

Test Plan:
All scenarios use N_CH=3, LVL_W=3, TICK_DIV=8, MAX_ACCEL_LOG=3, DECAY_SEC=2, FILL_STEP=2, LOW_THR=2, GRACE_SEC=3.
1. Release reset and idle: sec_tick_o pulses every 8 clks. After 16 clks all meters go 7->6; after 80 clks all are 2 and state_o = NEED one cycle later.
2. Three speed_pulses: accel_o = 3 and ticks come every 1 clk. A fourth pulse -> accel_o = 0 and the next tick arrives 8 clks later.
3. Meter at 6 + fill_pulse[1] -> level 7 (saturates, does not wrap to 0). Meter at 3 + fill -> 5. Other channels are unchanged.
4. Channel 0 at 0 with fill_pulse[0] on the decay-wrap cycle -> level 2 next cycle; zero_o[0] falls and the grace counter clears.
5. Channel 2 held at 0 with no fills -> CRITICAL, then DEAD after 3 ticks. Later fill and speed pulses leave levels and accel unchanged, while sec_tick_o keeps running. sick_in=1 while not dead -> SICK.
6. rst_neg low for 1 clk during DEAD at accel 2 -> next cycle meters = 7, accel_o = 0, state_o = OK, and ticks every 8 clks.

Source files
------------

// File: rtl/pet_pkg.sv
// Shared definitions for the pet needs engine: state encoding and saturating arithmetic.
package pet_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_OK       = 3'd0,
    ST_NEED     = 3'd1,
    ST_CRITICAL = 3'd2,
    ST_SICK     = 3'd3,
    ST_DEAD     = 3'd4
  } pet_state_e;

  // 32-bit arithmetic leaves headroom for any meter width up to 31 bits.
  function automatic int unsigned sat_add(input int unsigned v, input int unsigned step,
                                          input int unsigned max_v);
    return (v + step > max_v) ? max_v : v + step;
  endfunction

endpackage

// File: rtl/game_tick_gen.sv
// Game-second prescaler with a selectable 2^k acceleration exponent.
module game_tick_gen #(
  parameter int unsigned TICK_DIV      = 50_000_000,
  parameter int unsigned MAX_ACCEL_LOG = 3
) (
  input  logic                                 clk,
  input  logic                                 rst_neg,
  input  logic                                 speed_pulse,
  input  logic                                 freeze,
  output logic [$clog2(MAX_ACCEL_LOG+1)-1:0]   accel_o,
  output logic                                 sec_tick_o
);

  localparam int unsigned AccW = $clog2(MAX_ACCEL_LOG + 1);
  localparam int unsigned CntW = $clog2(TICK_DIV + 1);

  logic [AccW-1:0] accel_q, accel_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] period;
  logic            tick_q;
  logic            wrap;

  assign period = CntW'(TICK_DIV >> accel_q);
  assign wrap   = (cnt_q == period - 1'b1);

  always_comb begin
    accel_d = accel_q;
    cnt_d   = wrap ? '0 : cnt_q + 1'b1;
    // A speed change restarts the period; a coincident wrap still emits its tick.
    if (speed_pulse && !freeze) begin
      cnt_d   = '0;
      accel_d = (accel_q == AccW'(MAX_ACCEL_LOG)) ? '0 : accel_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_neg) begin
      accel_q <= '0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      accel_q <= accel_d;
      cnt_q   <= cnt_d;
      tick_q  <= wrap;
    end
  end

  assign accel_o    = accel_q;
  assign sec_tick_o = tick_q;

endmodule

// File: rtl/pet_needs_engine.sv
// Need meters with decay, saturating refill, grace-to-death timer and prioritised pet state.
module pet_needs_engine
  import pet_pkg::*;
#(
  parameter int unsigned N_CH          = 3,
  parameter int unsigned LVL_W         = 3,
  parameter int unsigned TICK_DIV      = 50_000_000,
  parameter int unsigned MAX_ACCEL_LOG = 3,
  parameter int unsigned DECAY_SEC     = 5,
  parameter int unsigned FILL_STEP     = 2,
  parameter int unsigned LOW_THR       = 2,
  parameter int unsigned GRACE_SEC     = 10
) (
  input  logic                               clk,
  input  logic                               rst_neg,
  input  logic [N_CH-1:0]                    fill_pulse,
  input  logic                               speed_pulse,
  input  logic                               sick_in,
  output logic [N_CH*LVL_W-1:0]              level_o,
  output logic [N_CH-1:0]                    zero_o,
  output logic [$clog2(MAX_ACCEL_LOG+1)-1:0] accel_o,
  output logic                               sec_tick_o,
  output logic [STATE_W-1:0]                 state_o
);

  localparam int unsigned MAX_LVL = (1 << LVL_W) - 1;
  localparam int unsigned DecW    = $clog2(DECAY_SEC + 1);
  localparam int unsigned GrW     = $clog2(GRACE_SEC + 1);

  logic [N_CH-1:0][LVL_W-1:0] lvl_q, lvl_d;
  logic [DecW-1:0]            dcnt_q, dcnt_d;
  logic [GrW-1:0]             grace_q, grace_d;
  logic                       dead_q, dead_d;
  pet_state_e                 state_q, state_d;
  logic [N_CH-1:0]            zero;
  logic                       any_low;
  logic                       any_zero_next;
  logic                       decay_wrap;
  logic                       sec_tick;

  game_tick_gen #(
    .TICK_DIV      (TICK_DIV),
    .MAX_ACCEL_LOG (MAX_ACCEL_LOG)
  ) u_tick (
    .clk         (clk),
    .rst_neg     (rst_neg),
    .speed_pulse (speed_pulse),
    .freeze      (dead_q),
    .accel_o     (accel_o),
    .sec_tick_o  (sec_tick)
  );

  always_comb begin
    zero    = '0;
    any_low = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      zero[i] = (lvl_q[i] == '0);
      if (32'(lvl_q[i]) <= LOW_THR) any_low = 1'b1;
    end
  end

  always_comb begin
    decay_wrap = sec_tick && !dead_q && (dcnt_q == DecW'(DECAY_SEC - 1));
    dcnt_d     = dcnt_q;
    if (sec_tick && !dead_q) dcnt_d = decay_wrap ? '0 : dcnt_q + 1'b1;

    // Decay is applied before the fill so an empty meter refilled on a wrap ends at FILL_STEP.
    lvl_d         = lvl_q;
    any_zero_next = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (!dead_q) begin
        if (decay_wrap && lvl_d[i] != '0) lvl_d[i] = lvl_d[i] - 1'b1;
        if (fill_pulse[i]) lvl_d[i] = LVL_W'(sat_add(32'(lvl_d[i]), FILL_STEP, MAX_LVL));
      end
      if (lvl_d[i] == '0) any_zero_next = 1'b1;
    end

    grace_d = grace_q;
    dead_d  = dead_q;
    if (!dead_q) begin
      if (!any_zero_next) begin
        grace_d = '0;
      end else if (sec_tick && |zero) begin
        grace_d = grace_q + 1'b1;
        if (grace_d == GrW'(GRACE_SEC)) dead_d = 1'b1;
      end
    end
  end

  // State is derived from the registered meters, so it trails level_o by one cycle.
  always_comb begin
    if (dead_q)       state_d = ST_DEAD;
    else if (sick_in) state_d = ST_SICK;
    else if (|zero)   state_d = ST_CRITICAL;
    else if (any_low) state_d = ST_NEED;
    else              state_d = ST_OK;
  end

  always_ff @(posedge clk) begin
    if (!rst_neg) begin
      lvl_q   <= '1;
      dcnt_q  <= '0;
      grace_q <= '0;
      dead_q  <= 1'b0;
      state_q <= ST_OK;
    end else begin
      lvl_q   <= lvl_d;
      dcnt_q  <= dcnt_d;
      grace_q <= grace_d;
      dead_q  <= dead_d;
      state_q <= state_d;
    end
  end

  assign level_o    = lvl_q;
  assign zero_o     = zero;
  assign sec_tick_o = sec_tick;
  assign state_o    = state_q;

endmodule
